// File: rtl/regfile_pkg.sv
// Shared constants, types and the write-enable decoder for the MIPS-style register file.
package regfile_pkg;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [WIDTH-1:0]  reg_data_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

  // One-hot write enable (RegWrite << WriteRegister) for entries 1..DEPTH-1.
  // Bit 0 is absent from the result: register 0 has no storage, so its
  // write enable is masked off by construction.
  function automatic logic [DEPTH-1:1] write_decode(input logic en, input reg_addr_t addr);
    logic [DEPTH-1:1] onehot;
    for (int i = 1; i < DEPTH; i++) begin
      onehot[i] = en && (addr == ADDR_W'(i));
    end
    return onehot;
  endfunction

endpackage

// File: rtl/register_we.sv
// Single register: WIDTH-bit flop with load enable and asynchronous active-high reset to 0.
module register_we #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Hold the stored value; load d on an enabled rising edge, clear at once on reset.
  // NOTE: non-blocking (<=) for all flop state so every register updates from pre-edge values.
  // NOTE: the register file is built from resettable flops, not a RAM, so every entry can be
  //       cleared asynchronously; a RAM macro would need a clear sequence instead.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/register_file.sv
// 32 x 32 MIPS-style register file: two combinational read ports, one synchronous write port,
// register 0 hardwired to zero, asynchronous active-high reset clearing entries 1..31.
// Optional macro REGFILE_BYPASS_EN: write-through forwarding of WriteData to a read port that
// addresses the register being written in the same cycle (never for r0, never during reset).
module register_file
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [WIDTH-1:0]  ReadData1,
  output logic [WIDTH-1:0]  ReadData2,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic              RegWrite
);

  logic [DEPTH-1:1] we_onehot;
  reg_data_t        entry [DEPTH];

  assign we_onehot = write_decode(RegWrite, WriteRegister);

  // Entry 0 has no storage element: it is the constant zero input of each read mux.
  assign entry[0] = '0;

  for (genvar i = 1; i < DEPTH; i++) begin : g_entry
    register_we #(.WIDTH(WIDTH)) u_reg (
      .clk   (clk),
      .reset (reset),
      .en    (we_onehot[i]),
      .d     (WriteData),
      .q     (entry[i])
    );
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd1;
  logic fwd2;

  // Forward the in-flight write to a port reading the same non-zero register, outside reset.
  assign fwd1 = !reset && RegWrite && (WriteRegister == ReadRegister1) && (ReadRegister1 != ZERO_REG);
  assign fwd2 = !reset && RegWrite && (WriteRegister == ReadRegister2) && (ReadRegister2 != ZERO_REG);

  // Read port 1: stored entry, or WriteData when forwarding.
  // NOTE: always_comb assigns a default first so every path drives the output (no latch).
  always_comb begin
    ReadData1 = entry[ReadRegister1];
    if (fwd1) ReadData1 = WriteData;
  end

  // Read port 2: stored entry, or WriteData when forwarding.
  always_comb begin
    ReadData2 = entry[ReadRegister2];
    if (fwd2) ReadData2 = WriteData;
  end
`else
  // Read port 1: DEPTH:1 mux over the entries; no forwarding, so a same-cycle write is seen next cycle.
  always_comb begin
    ReadData1 = entry[ReadRegister1];
  end

  // Read port 2: same mux structure as port 1.
  always_comb begin
    ReadData2 = entry[ReadRegister2];
  end
`endif

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: reference array of register contents, expected read
// values queued when the read addresses are driven and compared when the outputs are sampled.
module tb_register_file;

  logic        clk;
  logic        reset;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        RegWrite;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model [32];

  register_file dut (
    .clk           (clk),
    .reset         (reset),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .RegWrite      (RegWrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // Drive a write at the falling edge, let the rising edge commit it, return at the next falling edge.
  task automatic write_reg(input logic [4:0] a, input logic [31:0] d, input logic en);
    WriteRegister = a;
    WriteData     = d;
    RegWrite      = en;
    @(posedge clk);
    if (en && a != 5'd0 && !reset) model[a] = d;
    @(negedge clk);
    RegWrite = 1'b0;
  endtask

  // Drive both read addresses, queue the expected data, sample 1 ns later and compare.
  task automatic read_pair(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                           input logic [31:0] e1, input logic [31:0] e2);
    exp_t e;
    ReadRegister1 = a1;
    ReadRegister2 = a2;
    e.tag = {tag, "/rd1"}; e.value = e1; sb_q.push_back(e);
    e.tag = {tag, "/rd2"}; e.value = e2; sb_q.push_back(e);
    #1;
    e = sb_q.pop_front();
    check(e.tag, ReadData1, e.value);
    e = sb_q.pop_front();
    check(e.tag, ReadData2, e.value);
  endtask

  logic [31:0] same_cycle_exp;

  initial begin
    reset         = 1'b1;
    RegWrite      = 1'b0;
    WriteRegister = 5'd0;
    WriteData     = 32'h0;
    ReadRegister1 = 5'd0;
    ReadRegister2 = 5'd0;
    clear_model();

    // Reset held: reads are zero and a write edge during reset stores nothing.
    @(negedge clk);
    read_pair("reset_state", 5'd0, 5'd31, 32'h0, 32'h0);
    write_reg(5'd10, 32'h5A5A_5A5A, 1'b1);
    read_pair("write_in_reset", 5'd10, 5'd10, 32'h0, 32'h0);
    reset = 1'b0;

    // First edge after reset release writes.
    @(negedge clk);
    write_reg(5'd10, 32'hCAFE_F00D, 1'b1);
    read_pair("first_write_after_reset", 5'd10, 5'd1, model[10], 32'h0);

    // Reset asserted mid-cycle clears r5 before any clock edge.
    write_reg(5'd5, 32'hDEAD_BEEF, 1'b1);
    read_pair("r5_written", 5'd5, 5'd10, 32'hDEAD_BEEF, model[10]);
    #2;
    reset = 1'b1;
    clear_model();
    read_pair("async_reset_clear", 5'd5, 5'd10, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Basic write/read on both ports.
    write_reg(5'd7, 32'h1234_5678, 1'b1);
    read_pair("basic_r7", 5'd7, 5'd7, 32'h1234_5678, 32'h1234_5678);

    // Writes to r0 are dropped.
    write_reg(5'd0, 32'hFFFF_FFFF, 1'b1);
    read_pair("zero_reg", 5'd0, 5'd0, 32'h0, 32'h0);

    // RegWrite low leaves the addressed register untouched.
    write_reg(5'd9, 32'h1357_9BDF, 1'b1);
    write_reg(5'd9, 32'hAAAA_5555, 1'b0);
    read_pair("write_disabled", 5'd9, 5'd7, 32'h1357_9BDF, 32'h1234_5678);

    // Same-cycle read of the write target: old value without forwarding, new value with it.
    write_reg(5'd3, 32'h0000_0001, 1'b1);
`ifdef REGFILE_BYPASS_EN
    same_cycle_exp = 32'h0000_0002;
`else
    same_cycle_exp = 32'h0000_0001;
`endif
    WriteRegister = 5'd3;
    WriteData     = 32'h0000_0002;
    RegWrite      = 1'b1;
    read_pair("same_cycle_r3", 5'd3, 5'd0, same_cycle_exp, 32'h0);
    @(posedge clk);
    model[3] = 32'h0000_0002;
    @(negedge clk);
    RegWrite = 1'b0;
    read_pair("after_edge_r3", 5'd3, 5'd3, 32'h0000_0002, 32'h0000_0002);

    // Sweep: rk = k * 0x01010101, then every read-address pair.
    for (int k = 1; k < 32; k++) begin
      write_reg(5'(k), 32'(k) * 32'h0101_0101, 1'b1);
    end
    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        @(negedge clk);
        read_pair($sformatf("sweep_%0d_%0d", a, b), 5'(a), 5'(b),
                  32'(a) * 32'h0101_0101, 32'(b) * 32'h0101_0101);
      end
    end

    // A second reset wipes the full sweep.
    #2;
    reset = 1'b1;
    clear_model();
    read_pair("reset_after_sweep", 5'd31, 5'd16, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    read_pair("post_reset_r1", 5'd1, 5'd30, model[1], model[30]);

    if (sb_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
